// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arb CPU/debug memory arbiter.
// The optional round-robin arbitration is enabled with the ARB_RR_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit positions inside the status byte
  localparam int ST_DBG   = 0;
  localparam int ST_DACK  = 1;
  localparam int ST_CPU   = 2;
  localparam int ST_TMO   = 3;
  localparam int ST_STALL = 4;

  localparam int TMO_DEFAULT = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the CPU and the debug requester.
// ARB_RR_EN selects round-robin on a tie; otherwise debug always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic c_cs,
  input  logic d_cs,
  input  logic last_dbg,
  output logic grant_c,
  output logic grant_d
);

`ifdef ARB_RR_EN
  // On a tie the requester that was not served last wins
  always_comb begin
    grant_d = d_cs & (~c_cs | ~last_dbg);
    grant_c = c_cs & ~grant_d;
  end
`else
  logic unused_last;
  assign unused_last = last_dbg;

  // Fixed priority: debug first
  always_comb begin
    grant_d = d_cs;
    grant_c = c_cs & ~d_cs;
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-master (CPU, debug UART) single-port memory arbiter with ack timeout.
// Define ARB_RR_EN for round-robin arbitration instead of debug-first priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          c_cs,
  input  logic          c_r,
  input  logic [1:0]    c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          d_cs,
  input  logic          d_r,
  input  logic [1:0]    d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          m_cs,
  output logic          m_r,
  output logic [1:0]    m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  output logic [7:0]    status
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          tmo_q, tmo_d;
  logic          m_cs_q, m_cs_d;
  logic          m_r_q, m_r_d;
  logic [1:0]    m_wr_q, m_wr_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          c_ack_q, c_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [7:0]    status_q, status_d;
  logic          pick_c_s, pick_d_s;

  arb_pick u_pick (
    .c_cs     (c_cs),
    .d_cs     (d_cs),
    .last_dbg (last_q),
    .grant_c  (pick_c_s),
    .grant_d  (pick_d_s)
  );

  // Next-state, latched memory command, acks and status byte
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    m_cs_d    = m_cs_q;
    m_r_d     = m_r_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_c_s || pick_d_s) begin
          state_d   = pick_d_s ? DBG : CPU;
          last_d    = pick_d_s;
          cnt_d     = 8'd0;
          m_cs_d    = 1'b1;
          m_r_d     = pick_d_s ? d_r     : c_r;
          m_wr_d    = pick_d_s ? d_wr    : c_wr;
          m_addr_d  = pick_d_s ? d_addr  : c_addr;
          m_wdata_d = pick_d_s ? d_wdata : c_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      CPU, DBG: begin
        if (m_ack || (cnt_q == TMO_LAST)) begin
          state_d = DONE;
          cnt_d   = 8'd0;
          m_cs_d  = 1'b0;
          c_ack_d = (state_q == CPU);
          d_ack_d = (state_q == DBG);
          // A real ack on a debug read clears the sticky timeout; a timeout sets it
          if (!m_ack) begin
            tmo_d = 1'b1;
          end else if ((state_q == DBG) && m_r_q) begin
            tmo_d = 1'b0;
          end else begin
            tmo_d = tmo_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    status_d           = 8'h00;
    status_d[ST_DBG]   = (state_d == DBG);
    status_d[ST_DACK]  = d_ack_d;
    status_d[ST_CPU]   = (state_d == CPU);
    status_d[ST_TMO]   = tmo_d;
    status_d[ST_STALL] = c_cs & (state_d != CPU) & ~c_ack_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      last_q    <= 1'b0;
      tmo_q     <= 1'b0;
      m_cs_q    <= 1'b0;
      m_r_q     <= 1'b0;
      m_wr_q    <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      status_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      m_cs_q    <= m_cs_d;
      m_r_q     <= m_r_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      c_ack_q   <= c_ack_d;
      d_ack_q   <= d_ack_d;
      status_q  <= status_d;
    end
  end

  assign m_cs    = m_cs_q;
  assign m_r     = m_r_q;
  assign m_wr    = m_wr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign c_ack   = c_ack_q;
  assign d_ack   = d_ack_q;
  assign status  = status_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb; expectations depend on ARB_RR_EN.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic        c_cs, c_r, d_cs, d_r, m_ack;
  logic [1:0]  c_wr, d_wr;
  logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, d_ack, m_cs, m_r;
  logic [1:0]  m_wr;
  logic [15:0] m_addr, m_wdata;
  logic [7:0]  status;
  int checks = 0;
  int errors = 0;

  mem_arb #(.AW(16), .DW(16), .TMO(15)) dut (
    .clk(clk), .nreset(nreset),
    .c_cs(c_cs), .c_r(c_r), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .d_cs(d_cs), .d_r(d_r), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .m_cs(m_cs), .m_r(m_r), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_cs = 1'b0; c_r = 1'b0; c_wr = 2'b00; c_addr = 16'h0000; c_wdata = 16'h0000;
    d_cs = 1'b0; d_r = 1'b0; d_wr = 2'b00; d_addr = 16'h0000; d_wdata = 16'h0000;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_ack = 1'b0;
    do_reset();
    checks++;
    if ({m_cs, m_r, m_wr, m_addr, m_wdata, c_ack, d_ack, status} !== 44'h0) begin
      errors++;
      $display("FAIL reset_outputs: got cs=%b r=%b wr=%b addr=%h wdata=%h cack=%b dack=%b st=%h exp all 0",
               m_cs, m_r, m_wr, m_addr, m_wdata, c_ack, d_ack, status);
    end
  endtask

  task automatic test_arb();
    logic [15:0] exp_addr;
    do_reset();
    m_ack = 1'b1;
    c_cs = 1'b1; c_r = 1'b1; c_addr = 16'h1111;
    d_cs = 1'b1; d_r = 1'b1; d_addr = 16'h2222;
    for (int i = 0; i < 3; i++) begin
`ifdef ARB_RR_EN
      exp_addr = (i == 1) ? 16'h1111 : 16'h2222;
`else
      exp_addr = 16'h2222;
`endif
      tick();
      checks++;
      if (m_cs !== 1'b1 || m_addr !== exp_addr) begin
        errors++;
        $display("FAIL arb_grant%0d: got cs=%b addr=%h exp cs=1 addr=%h", i, m_cs, m_addr, exp_addr);
      end
      checks++;
      if (status[4] !== (exp_addr == 16'h2222)) begin
        errors++;
        $display("FAIL arb_stall%0d: got status[4]=%b exp %b", i, status[4], (exp_addr == 16'h2222));
      end
      tick();
      checks++;
      if (c_ack !== (exp_addr == 16'h1111) || d_ack !== (exp_addr == 16'h2222)) begin
        errors++;
        $display("FAIL arb_ack%0d: got cack=%b dack=%b exp cack=%b dack=%b", i, c_ack, d_ack,
                 (exp_addr == 16'h1111), (exp_addr == 16'h2222));
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_cpu_write();
    int mcs_cycles = 0;
    m_ack = 1'b1;
    c_cs = 1'b1; c_r = 1'b0; c_wr = 2'b11; c_addr = 16'h0100; c_wdata = 16'hBEEF;
    tick();
    c_cs = 1'b0; c_addr = 16'hFFFF; c_wdata = 16'h0000;
    checks++;
    if (m_cs !== 1'b1 || m_addr !== 16'h0100 || m_wdata !== 16'hBEEF || m_wr !== 2'b11 || c_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_cmd: got cs=%b addr=%h wdata=%h wr=%b cack=%b exp 1 0100 beef 11 0",
               m_cs, m_addr, m_wdata, m_wr, c_ack);
    end
    mcs_cycles += int'(m_cs);
    tick();
    checks++;
    if (c_ack !== 1'b1 || m_cs !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_ack: got cack=%b cs=%b dack=%b exp 1 0 0", c_ack, m_cs, d_ack);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      mcs_cycles += int'(m_cs);
      checks++;
      if (c_ack !== 1'b0) begin
        errors++;
        $display("FAIL cpu_wr_ack_drop%0d: got cack=%b exp 0", k, c_ack);
      end
    end
    checks++;
    if (mcs_cycles !== 1) begin
      errors++;
      $display("FAIL cpu_wr_mcs_len: got %0d cycles exp 1", mcs_cycles);
    end
  endtask

  task automatic test_dbg_write();
    int acks = 0;
    m_ack = 1'b1;
    d_cs = 1'b1; d_r = 1'b0; d_wr = 2'b01; d_addr = 16'h0003; d_wdata = 16'h5A5A;
    tick();
    d_cs = 1'b0;
    checks++;
    if (m_cs !== 1'b1 || m_wr !== 2'b01 || m_addr !== 16'h0003 || m_wdata !== 16'h5A5A || status[0] !== 1'b1) begin
      errors++;
      $display("FAIL dbg_wr_cmd: got cs=%b wr=%b addr=%h wdata=%h st0=%b exp 1 01 0003 5a5a 1",
               m_cs, m_wr, m_addr, m_wdata, status[0]);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      acks += int'(d_ack);
      if (k == 0) begin
        checks++;
        if (d_ack !== 1'b1 || status[1] !== 1'b1 || status[0] !== 1'b0 || c_ack !== 1'b0) begin
          errors++;
          $display("FAIL dbg_wr_ack: got dack=%b st1=%b st0=%b cack=%b exp 1 1 0 0", d_ack, status[1], status[0], c_ack);
        end
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL dbg_wr_ack_count: got %0d exp 1", acks);
    end
  endtask

  task automatic test_nop();
    m_ack = 1'b1;
    c_cs = 1'b1; c_r = 1'b0; c_wr = 2'b00; c_addr = 16'h0042;
    tick();
    c_cs = 1'b0;
    checks++;
    if (m_cs !== 1'b1 || m_r !== 1'b0 || m_wr !== 2'b00 || m_addr !== 16'h0042) begin
      errors++;
      $display("FAIL nop_cmd: got cs=%b r=%b wr=%b addr=%h exp 1 0 00 0042", m_cs, m_r, m_wr, m_addr);
    end
    tick();
    checks++;
    if (c_ack !== 1'b1) begin
      errors++;
      $display("FAIL nop_ack: got cack=%b exp 1", c_ack);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    m_ack = 1'b0;
    c_cs = 1'b1; c_r = 1'b1; c_addr = 16'h0777;
    tick();
    c_cs = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (c_ack !== 1'b0 || m_cs !== 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL tmo_early: got %0d bad cycles before timeout exp 0", early);
    end
    tick();
    checks++;
    if (c_ack !== 1'b1 || m_cs !== 1'b0 || status[3] !== 1'b1) begin
      errors++;
      $display("FAIL tmo_ack: got cack=%b cs=%b st3=%b exp 1 0 1", c_ack, m_cs, status[3]);
    end
    tick();
    d_cs = 1'b1; d_r = 1'b1; d_wr = 2'b00; d_addr = 16'h0010;
    tick();
    d_cs = 1'b0;
    checks++;
    if (status[3] !== 1'b1 || status[0] !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: got st3=%b st0=%b exp 1 1", status[3], status[0]);
    end
    m_ack = 1'b1;
    tick();
    checks++;
    if (d_ack !== 1'b1 || status[3] !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got dack=%b st3=%b exp 1 0", d_ack, status[3]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    m_ack = 1'b0;
    d_cs = 1'b1; d_r = 1'b1; d_wr = 2'b10; d_addr = 16'hABCD; d_wdata = 16'h1234;
    tick();
    d_cs = 1'b0;
    tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    checks++;
    if ({m_cs, m_r, m_wr, m_addr, m_wdata, c_ack, d_ack, status} !== 44'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got cs=%b r=%b wr=%b addr=%h wdata=%h cack=%b dack=%b st=%h exp all 0",
               m_cs, m_r, m_wr, m_addr, m_wdata, c_ack, d_ack, status);
    end
    m_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      acks += int'(d_ack) + int'(m_cs);
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL rst_mid_idle: got %0d dack/cs cycles exp 0", acks);
    end
  endtask

  task automatic test_early_drop();
    int cpu_seen = 0;
    m_ack = 1'b0;
    d_cs = 1'b1; d_r = 1'b0; d_wr = 2'b11; d_addr = 16'h0020;
    tick();
    d_cs = 1'b0;
    c_cs = 1'b1; c_addr = 16'h0999;
    tick();
    c_cs = 1'b0;
    checks++;
    if (status[4] !== 1'b1 || status[0] !== 1'b1) begin
      errors++;
      $display("FAIL drop_stall: got st4=%b st0=%b exp 1 1", status[4], status[0]);
    end
    m_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      cpu_seen += int'(c_ack) + int'(status[2]) + int'(m_addr == 16'h0999);
    end
    checks++;
    if (cpu_seen !== 0) begin
      errors++;
      $display("FAIL drop_no_cpu: got %0d cpu activity cycles exp 0", cpu_seen);
    end
  endtask

  initial begin
    nreset = 1'b0;
    m_ack = 1'b0;
    idle_inputs();
    test_reset();
    test_arb();
    test_cpu_write();
    test_dbg_write();
    test_nop();
    test_timeout();
    test_reset_mid();
    test_early_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter: AW, 16, address width.
REQ-002 SHALL have parameter: DW, 16, data width (two byte lanes).
REQ-003 SHALL have parameter: TMO, 15, memory-ack timeout in cycles (1..255).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on posedge.
- nreset  in  1  reset, synchronous and active-low.
- c_cs  in  1  CPU request.
- c_r  in  1  CPU read.
- c_wr  in  2  CPU byte-lane writes: [1] high byte, [0] low byte.
- c_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_ack  out  1  CPU access done.
- d_cs  in  1  debug request (debug UART csu).
- d_r  in  1  debug read.
- d_wr  in  2  debug byte-lane writes.
- d_addr  in  AW  debug address.
- d_wdata  in  DW  debug write data.
- d_ack  out  1  debug access done.
- m_cs  out  1  memory strobe.
- m_r  out  1  memory read.
- m_wr  out  2  memory byte-lane writes.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_ack  in  1  memory ready.
- status  out  8  status byte for the debug UART 'i' command.

Function
REQ-005 SHALL implement FSM IDLE, CPU, DBG, DONE.
REQ-006 In IDLE with a request pending, SHALL latch the winner's r/wr/addr/wdata into m_* on that clock edge, go to CPU or DBG, and assert m_cs from the next cycle.
REQ-007 SHALL keep m_* constant while in CPU/DBG; requester inputs are ignored after the latch.
REQ-008 In CPU/DBG, when m_cs is high and m_ack is high, SHALL pulse the matching c_ack/d_ack for exactly 1 cycle, drop m_cs, and go to DONE.
REQ-009 DONE SHALL last 1 cycle, then return to IDLE; minimum request-to-request spacing is 3 cycles.
REQ-010 SHALL count cycles in CPU/DBG with an 8-bit counter. At count == TMO without m_ack it SHALL:
- pulse the requester's ack;
- set sticky status[3] (timeout);
- drop m_cs;
- go to DONE.
REQ-011 Read data SHALL NOT be muxed by this block; requesters sample memory data directly when their ack is high.
REQ-012 c_ack and d_ack SHALL never be high in the same cycle.
REQ-013 status bits:
- [0] debug grant active (DBG state).
- [1] d_ack.
- [2] CPU grant active.
- [3] timeout sticky.
- [4] CPU stalled: c_cs high while not granted.
- [7:5] = 0.
REQ-014 Sticky status[3] SHALL clear on the cycle d_ack completes a debug read.
REQ-015 A requester dropping cs before its grant SHALL NOT be granted.
REQ-016 A requester dropping cs after the latch SHALL still see its access complete and its ack pulse.
REQ-017 A request with r=0 and wr=0 SHALL be granted and acked like any other access.

Reset
REQ-018 With nreset low at a posedge, SHALL go to IDLE and clear the counter.
REQ-019 Reset values: m_cs=0, m_r=0, m_wr=0, m_addr=0, m_wdata=0, c_ack=0, d_ack=0, status=0.
REQ-020 Reset mid-access SHALL abort the access with no ack pulse.

Configuration
REQ-021 With ARB_RR_EN defined, IDLE arbitration SHALL be round-robin:
- on a simultaneous request, the requester not served last wins;
- the last-served flag resets to CPU, so debug wins the first tie.
REQ-022 Without ARB_RR_EN, debug SHALL always win a simultaneous request (fixed priority); the CPU can be starved by back-to-back debug requests.

Structure
REQ-023 Shared package mem_arb_pkg SHALL hold:
- the state enum (IDLE, CPU, DBG, DONE);
- status bit-index constants;
- the default TMO value.
REQ-024 Sub-module arb_pick SHALL be combinational: inputs c_cs, d_cs, last-served flag; outputs grant_c, grant_d.
REQ-025 Everything else SHALL be one sequential process in mem_arb.

Verification
REQ-026 Single CPU write: c_cs=1, c_wr=2'b11, c_addr=16'h0100, c_wdata=16'hBEEF, m_ack tied high -> m_cs high 1 cycle with m_addr=16'h0100, m_wdata=16'hBEEF; c_ack 1-cycle pulse.
REQ-027 Simultaneous c_cs and d_cs after reset:
- ARB_RR_EN: debug, CPU, debug on three repeats.
- No ARB_RR_EN: debug every time, status[4]=1 while CPU waits.
REQ-028 Debug low-byte write: d_wr=2'b01, d_addr=16'h0003, d_wdata=16'h5A5A -> m_wr=2'b01, m_addr=16'h0003; d_ack once; status[0] high during grant.
REQ-029 Timeout: m_ack held low, TMO=15 -> ack pulses 15 cycles after m_cs rises, status[3]=1; a later debug read clears it.
REQ-030 Reset mid-access: nreset low on the 2nd cycle of a DBG access -> no d_ack; all outputs 0 next cycle; IDLE.
REQ-031 Early drop: c_cs pulsed 1 cycle while DBG busy -> no CPU access is ever started.
